// File: rtl/alu_issue_ctrl_pkg.sv
// Shared types for the ALU issue controller.
// ALU_ISSUE_PERF_EN adds arith/shift issue counters to the top.
package alu_issue_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    WB
  } state_t;

  localparam int SHIFT_W = 1;
  localparam int OPSEL_W = 3;
  localparam int OP_W    = 3;
  localparam int SHAMT_W = 5;
  localparam int FIXED_W = SHIFT_W + OPSEL_W + OP_W + SHAMT_W;

  localparam int SHIFT_OFS = 1;
  localparam int OPSEL_OFS = SHIFT_OFS + OPSEL_W;
  localparam int OP_OFS    = OPSEL_OFS + OP_W;

  // Register indices depend on NREGS, so they live beside this struct.
  typedef struct packed {
    logic         is_shift;
    logic [2:0]   opselect;
    logic [2:0]   operation;
    logic [4:0]   shamt;
  } alu_instr_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Instruction handshake between the host and the issue controller.
// Widths follow REG_AW.
interface alu_issue_ctrl_if #(
  parameter int REG_AW = 3
);
  import alu_issue_pkg::*;

  localparam int W = FIXED_W + 3 * REG_AW;

  logic         instr_valid;
  logic         instr_ready;
  logic [W-1:0] instr;

  modport master (
    output instr_valid,
    output instr,
    input  instr_ready
  );

  modport slave (
    input  instr_valid,
    input  instr,
    output instr_ready
  );

endinterface

// File: rtl/alu_issue_rf.sv
// Register file: two operand read ports, one host read port,
// writeback and host writes with writeback winning on a clash.
module alu_issue_rf #(
  parameter int NREGS = 8,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [AW-1:0] raddr1,
  input  logic [AW-1:0] raddr2,
  output logic [31:0]   rdata1,
  output logic [31:0]   rdata2,
  input  logic [AW-1:0] host_raddr,
  output logic [31:0]   host_rdata,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_addr,
  input  logic [31:0]   wb_data,
  input  logic          host_we,
  input  logic [AW-1:0] host_waddr,
  input  logic [31:0]   host_wdata
);

  logic [31:0] mem [NREGS];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++)
        mem[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (wb_we && wb_addr == AW'(i))
          mem[i] <= wb_data;
        else if (host_we && host_waddr == AW'(i))
          mem[i] <= host_wdata;
      end
    end
  end

  assign rdata1     = mem[raddr1];
  assign rdata2     = mem[raddr2];
  assign host_rdata = mem[host_raddr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Serial ALU issue controller: decode, issue, wait, write back.
// ALU_ISSUE_PERF_EN adds arith_count/shift_count outputs.
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter  int NREGS       = 8,
  parameter  int ALU_LATENCY = 1,
  localparam int REG_AW      = $clog2(NREGS)
) (
  input  logic              clock,
  input  logic              reset,
  alu_issue_ctrl_if.slave   ibus,
  input  logic              host_we,
  input  logic [REG_AW-1:0] host_waddr,
  input  logic [31:0]       host_wdata,
  input  logic [REG_AW-1:0] host_raddr,
  output logic [31:0]       host_rdata,
  output logic [31:0]       aluin1,
  output logic [31:0]       aluin2,
  output logic [2:0]        opselect,
  output logic [2:0]        operation,
  output logic [4:0]        shift_number,
  output logic              enable_arith,
  output logic              enable_shift,
  input  logic [31:0]       aluout,
  input  logic              carryout,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_addr,
  output logic [31:0]       wb_data,
  output logic              carry_flag,
  output logic              busy
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [31:0]       arith_count,
  output logic [31:0]       shift_count
`endif
);

  localparam int W  = FIXED_W + 3 * REG_AW;
  localparam int CW =
    (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;
  localparam int RD_HI  = W - 1 - OP_OFS;
  localparam int RS1_HI = RD_HI - REG_AW;
  localparam int RS2_HI = RS1_HI - REG_AW;

  state_t            state, state_nx;
  alu_instr_t        ins_q;
  logic [REG_AW-1:0] rd_q, rs1_q, rs2_q;
  logic [CW-1:0]     cnt;
  logic [31:0]       op1_q, op2_q;
  logic [31:0]       rd1, rd2;
  logic              accept;

  assign accept = ibus.instr_valid && ibus.instr_ready;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx         = state;
    ibus.instr_ready = 1'b0;
    enable_arith     = 1'b0;
    enable_shift     = 1'b0;
    wb_valid         = 1'b0;
    unique case (state)
      IDLE: begin
        ibus.instr_ready = !reset;
        if (ibus.instr_valid && !reset)
          state_nx = ISSUE;
      end
      ISSUE: begin
        enable_shift = ins_q.is_shift && !reset;
        enable_arith = !ins_q.is_shift && !reset;
        state_nx = (ALU_LATENCY == 1) ? WB : WAIT;
      end
      WAIT: begin
        if (cnt == CW'(1))
          state_nx = WB;
      end
      WB: begin
        wb_valid = !reset;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ins_q      <= '0;
      rd_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      cnt        <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      carry_flag <= 1'b0;
    end else begin
      if (accept) begin
        ins_q.is_shift  <= ibus.instr[W-SHIFT_OFS];
        ins_q.opselect  <= ibus.instr[W-1-SHIFT_OFS -: OPSEL_W];
        ins_q.operation <= ibus.instr[W-1-OPSEL_OFS -: OP_W];
        ins_q.shamt     <= ibus.instr[SHAMT_W-1:0];
        rd_q            <= ibus.instr[RD_HI -: REG_AW];
        rs1_q           <= ibus.instr[RS1_HI -: REG_AW];
        rs2_q           <= ibus.instr[RS2_HI -: REG_AW];
      end
      // Operands are captured so they stay stable through WAIT/WB.
      if (state == ISSUE) begin
        op1_q <= rd1;
        op2_q <= rd2;
        cnt   <= CW'(ALU_LATENCY - 1);
      end else if (state == WAIT) begin
        cnt <= cnt - 1'b1;
      end
      if (state == WB)
        carry_flag <= carryout;
    end
  end

  assign aluin1       = (state == ISSUE) ? rd1 : op1_q;
  assign aluin2       = (state == ISSUE) ? rd2 : op2_q;
  assign opselect     = ins_q.opselect;
  assign operation    = ins_q.operation;
  assign shift_number = ins_q.shamt;
  assign wb_addr      = wb_valid ? rd_q : '0;
  assign wb_data      = wb_valid ? aluout : '0;
  assign busy         = (state != IDLE);

  alu_issue_rf #(
    .NREGS (NREGS),
    .AW    (REG_AW)
  ) u_rf (
    .clock      (clock),
    .reset      (reset),
    .raddr1     (rs1_q),
    .raddr2     (rs2_q),
    .rdata1     (rd1),
    .rdata2     (rd2),
    .host_raddr (host_raddr),
    .host_rdata (host_rdata),
    .wb_we      (wb_valid),
    .wb_addr    (rd_q),
    .wb_data    (aluout),
    .host_we    (host_we),
    .host_waddr (host_waddr),
    .host_wdata (host_wdata)
  );

`ifdef ALU_ISSUE_PERF_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      arith_count <= '0;
      shift_count <= '0;
    end else begin
      if (enable_arith) arith_count <= arith_count + 1'b1;
      if (enable_shift) shift_count <= shift_count + 1'b1;
    end
  end
`endif

endmodule
